// File: rtl/bus_mem_slave_pkg.sv
// Shared OCP-style bus types and helpers used by the memory target and its bench.
package bus_mem_slave_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RDEX = 3'd3,
    RDL  = 3'd4,
    WRNP = 3'd5,
    WRC  = 3'd6,
    BCST = 3'd7
  } Ocp_cmd;

  typedef enum logic [1:0] {
    NULL = 2'd0,
    DVA  = 2'd1,
    FAIL = 2'd2,
    ERR  = 2'd3
  } Ocp_resp;

  // Number of byte-offset bits below the word index for a given data width.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/bus_mem_slave_if.sv
// OCP-style request/response bus between a master and a memory target.
interface bus_mem_slave_if
  import bus_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   MAddr;
  Ocp_cmd                  MCmd;
  logic [DATA_WIDTH-1:0]   MData;
  logic                    MDataValid;
  logic [DATA_WIDTH/8-1:0] MByteEn;
  logic                    MRespAccept;
  logic                    SCmdAccept;
  logic                    SDataAccept;
  logic [DATA_WIDTH-1:0]   SData;
  Ocp_resp                 SResp;

  modport master (
    output MAddr, MCmd, MData, MDataValid, MByteEn, MRespAccept,
    input  SCmdAccept, SDataAccept, SData, SResp
  );

  modport slave (
    input  MAddr, MCmd, MData, MDataValid, MByteEn, MRespAccept,
    output SCmdAccept, SDataAccept, SData, SResp
  );

endinterface

// File: rtl/bus_mem_slave_resp_fifo.sv
// Synchronous FIFO whose head entry is held in a register; the head reads as zero when empty.
module bus_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]    count_q, count_next;
  logic [WIDTH-1:0] head_q, head_next;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The next head is the freshly pushed entry only when it lands where the read pointer will be.
  always_comb begin
    rd_next    = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
    count_next = count_q;
    if (do_push && !do_pop)
      count_next = count_q + 1'b1;
    else if (do_pop && !do_push)
      count_next = count_q - 1'b1;
    head_next = '0;
    if (count_next != '0) begin
      if (do_push && (rd_next == wr_ptr))
        head_next = din;
      else
        head_next = storage[rd_next];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= din;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      rd_ptr  <= rd_next;
      count_q <= count_next;
      head_q  <= head_next;
    end
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed memory target on the OCP-style bus; responses leave through a small in-order queue.
module bus_mem_slave
  import bus_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RESP_DEPTH = 2,
  parameter bit BYTEEN     = 1'b0,
  parameter bit WRITE_RESP = 1'b1
) (
  input logic            Clk,
  input logic            Reset,
  bus_mem_slave_if.slave bus
);

  localparam int LSB   = addr_lsb(DATA_WIDTH);
  localparam int MW    = $clog2(DEPTH);
  localparam int CW    = $clog2(RESP_DEPTH + 1);
  localparam int LANES = DATA_WIDTH / 8;

  typedef struct packed {
    Ocp_resp               resp;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  reset_q;
  logic [ADDR_WIDTH-1:0] word;
  logic [MW-1:0]         idx;
  logic                  in_range, is_rd, is_wr;
  logic                  cmd_accept, accept, push, pop;
  resp_t                 entry, head;
  logic [CW-1:0]         count;
  logic                  q_full, q_empty;

  assign word     = bus.MAddr >> LSB;
  assign idx      = word[MW-1:0];
  assign in_range = (word < ADDR_WIDTH'(DEPTH));
  assign is_rd    = (bus.MCmd == RD);
  assign is_wr    = (bus.MCmd == WR);

  // Acceptance looks only at registered state; posted writes never need a queue slot.
  always_comb begin
    cmd_accept = !reset_q && (count < CW'(RESP_DEPTH));
    if (!WRITE_RESP && is_wr)
      cmd_accept = !reset_q;
  end

  assign accept = (bus.MCmd != IDLE) && cmd_accept && !Reset;
  assign push   = accept && !(is_wr && !WRITE_RESP);
  assign pop    = !q_empty && bus.MRespAccept;

  always_comb begin
    entry = '{resp: ERR, data: '0};
    if (in_range && is_rd)
      entry = '{resp: DVA, data: mem[idx]};
    else if (in_range && is_wr)
      entry = '{resp: DVA, data: '0};
  end

  always_ff @(posedge Clk) begin
    reset_q <= Reset;
  end

  // Memory is deliberately left uninitialised across reset.
  always_ff @(posedge Clk) begin
    if (accept && is_wr && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (!BYTEEN || bus.MByteEn[i])
          mem[idx][8*i +: 8] <= bus.MData[8*i +: 8];
      end
    end
  end

  bus_resp_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (count)
  );

  assign bus.SCmdAccept  = cmd_accept;
  assign bus.SDataAccept = cmd_accept;
  assign bus.SResp       = head.resp;
  assign bus.SData       = head.data;

endmodule
